// File: rtl/interrupt_controller.sv
// Edge-triggered, maskable, fixed-priority interrupt controller with a req/ack/done CPU handshake.
// Line 0 has the highest priority. Only one interrupt is in service at a time.
module interrupt_controller #(
  parameter int               N_IRQ      = 8,
  parameter int               VEC_W      = 3,
  parameter logic [N_IRQ-1:0] MASK_RESET = 8'hFF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_IRQ-1:0] irq_in,
  input  logic             mask_we,
  input  logic [N_IRQ-1:0] mask_in,
  input  logic             int_ack,
  input  logic             int_done,
  output logic             int_req,
  output logic [VEC_W-1:0] int_vector,
  output logic             in_service,
  output logic [N_IRQ-1:0] pending,
  output logic [N_IRQ-1:0] mask
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQUEST = 2'd1,
    SERVICE = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [N_IRQ-1:0]   r_irq_prev;
  logic [N_IRQ-1:0]   r_pending;
  logic [N_IRQ-1:0]   r_mask;
  logic [VEC_W-1:0]   r_vector;
  logic               r_int_req;
  logic               r_in_service;

  logic [N_IRQ-1:0]   w_rise;
  logic [N_IRQ-1:0]   w_eligible;
  logic [N_IRQ-1:0]   w_clr;
  logic [VEC_W-1:0]   w_sel;
  logic               w_ack_fire;
  logic               w_load_vec;

  function automatic logic [VEC_W-1:0] sel_lowest(input logic [N_IRQ-1:0] v);
    sel_lowest = '0;
    for (int i = N_IRQ - 1; i >= 0; i--) begin
      if (v[i]) sel_lowest = VEC_W'(i);
    end
  endfunction

  assign w_rise     = irq_in & ~r_irq_prev;
  assign w_eligible = r_pending & r_mask;
  assign w_sel      = sel_lowest(w_eligible);
  assign w_ack_fire = (r_state == REQUEST) && int_ack;
  assign w_clr      = w_ack_fire ? ({{(N_IRQ-1){1'b0}}, 1'b1} << r_vector) : '0;

  always_comb begin
    w_state_nxt = r_state;
    w_load_vec  = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_eligible != '0) begin
          w_state_nxt = REQUEST;
          w_load_vec  = 1'b1;
        end
      end
      REQUEST: begin
        if (int_ack) w_state_nxt = SERVICE;
      end
      SERVICE: begin
        if (int_done) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Edge history is loaded during reset so lines already high at release raise no event.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state      <= IDLE;
      r_irq_prev   <= irq_in;
      r_pending    <= '0;
      r_mask       <= MASK_RESET;
      r_vector     <= '0;
      r_int_req    <= 1'b0;
      r_in_service <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_irq_prev   <= irq_in;
      // A new edge on the line being acknowledged wins over the clear.
      r_pending    <= (r_pending & ~w_clr) | w_rise;
      if (mask_we) r_mask <= mask_in;
      if (w_load_vec) r_vector <= w_sel;
      r_int_req    <= (w_state_nxt == REQUEST);
      r_in_service <= (w_state_nxt == SERVICE);
    end
  end

  assign int_req    = r_int_req;
  assign int_vector = r_vector;
  assign in_service = r_in_service;
  assign pending    = r_pending;
  assign mask       = r_mask;

endmodule

// File: tb/tb_interrupt_controller.sv
// Scoreboard bench for interrupt_controller: expected request vectors are queued by the
// stimulus and popped by a monitor on each new int_req; status is checked inline.
module tb_interrupt_controller;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] irq_in;
  logic       mask_we;
  logic [7:0] mask_in;
  logic       int_ack;
  logic       int_done;
  logic       int_req;
  logic [2:0] int_vector;
  logic       in_service;
  logic [7:0] pending;
  logic [7:0] mask;

  int n_vec = 0;
  int n_err = 0;
  logic [2:0] exp_q[$];
  logic mon_en   = 1'b0;
  logic mon_prev = 1'b0;

  interrupt_controller #(.N_IRQ(8), .VEC_W(3), .MASK_RESET(8'hFF)) dut (
    .clk        (clk),
    .reset      (reset),
    .irq_in     (irq_in),
    .mask_we    (mask_we),
    .mask_in    (mask_in),
    .int_ack    (int_ack),
    .int_done   (int_done),
    .int_req    (int_req),
    .int_vector (int_vector),
    .in_service (in_service),
    .pending    (pending),
    .mask       (mask)
  );

  always #5 clk = ~clk;

  // Monitor: each new request must match the oldest queued expectation.
  always @(negedge clk) begin
    if (mon_en) begin
      if (int_req && !mon_prev) begin
        n_vec++;
        if (exp_q.size() == 0) begin
          n_err++;
          $display("FAIL req_unexpected: got vector %0d, none expected", int_vector);
        end else begin
          logic [2:0] e;
          e = exp_q.pop_front();
          if (int_vector !== e) begin
            n_err++;
            $display("FAIL req_vector: got %0d, expected %0d", int_vector, e);
          end
        end
      end
      mon_prev = int_req;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic ack_done();
    int_ack = 1'b1; step(); int_ack = 1'b0;
    chk("ack_req_low", {7'b0, int_req}, 8'h00);
    chk("ack_in_service", {7'b0, in_service}, 8'h01);
    int_done = 1'b1; step(); int_done = 1'b0;
    chk("done_in_service", {7'b0, in_service}, 8'h00);
  endtask

  initial begin
    reset = 1'b0; irq_in = 8'h01; mask_we = 1'b0; mask_in = 8'h00;
    int_ack = 1'b0; int_done = 1'b0;
    step(); step();
    chk("rst_pending", pending, 8'h00);
    chk("rst_mask", mask, 8'hFF);
    chk("rst_req", {7'b0, int_req}, 8'h00);
    chk("rst_vector", {5'b0, int_vector}, 8'h00);
    chk("rst_in_service", {7'b0, in_service}, 8'h00);
    mon_en = 1'b1;

    // Line 0 held high across reset release: no event.
    reset = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      chk("held_pending", pending, 8'h00);
      chk("held_req", {7'b0, int_req}, 8'h00);
    end
    irq_in = 8'h00; step();

    // Single pulse on line 3.
    exp_q.push_back(3'd3);
    irq_in = 8'h08; step(); irq_in = 8'h00;
    chk("l3_pending", pending, 8'h08);
    chk("l3_req_early", {7'b0, int_req}, 8'h00);
    step();
    chk("l3_req", {7'b0, int_req}, 8'h01);
    chk("l3_vector", {5'b0, int_vector}, 8'h03);
    ack_done();
    chk("l3_pending_clr", pending, 8'h00);
    step();

    // Lines 5 and 2 together: 2 first, then 5.
    exp_q.push_back(3'd2);
    exp_q.push_back(3'd5);
    irq_in = 8'h24; step(); irq_in = 8'h00;
    chk("p25_pending", pending, 8'h24);
    step();
    chk("p25_vec_first", {5'b0, int_vector}, 8'h02);
    ack_done();
    chk("p25_pending_mid", pending, 8'h20);
    step();
    chk("p25_req2", {7'b0, int_req}, 8'h01);
    chk("p25_vec_second", {5'b0, int_vector}, 8'h05);
    ack_done();
    chk("p25_pending_end", pending, 8'h00);
    step();

    // Masked line 0 becomes eligible only after unmasking.
    mask_we = 1'b1; mask_in = 8'hFE; step(); mask_we = 1'b0;
    chk("mask_fe", mask, 8'hFE);
    irq_in = 8'h01; step(); irq_in = 8'h00;
    chk("m0_pending", pending, 8'h01);
    step(); step();
    chk("m0_req_masked", {7'b0, int_req}, 8'h00);
    exp_q.push_back(3'd0);
    mask_we = 1'b1; mask_in = 8'hFF; step(); mask_we = 1'b0;
    chk("m0_req_old_mask", {7'b0, int_req}, 8'h00);
    step();
    chk("m0_req", {7'b0, int_req}, 8'h01);
    chk("m0_vector", {5'b0, int_vector}, 8'h00);
    ack_done();
    step();

    // New edge on line 4 coincident with its ack keeps it pending.
    exp_q.push_back(3'd4);
    exp_q.push_back(3'd4);
    irq_in = 8'h10; step(); irq_in = 8'h00;
    step();
    chk("l4_vector", {5'b0, int_vector}, 8'h04);
    int_ack = 1'b1; irq_in = 8'h10; step(); int_ack = 1'b0; irq_in = 8'h00;
    chk("l4_in_service", {7'b0, in_service}, 8'h01);
    chk("l4_pending_kept", pending, 8'h10);
    int_done = 1'b1; step(); int_done = 1'b0;
    step();
    chk("l4_req_again", {7'b0, int_req}, 8'h01);
    chk("l4_vector_again", {5'b0, int_vector}, 8'h04);
    ack_done();
    chk("l4_pending_end", pending, 8'h00);
    step();

    // Reset during service discards pending events.
    exp_q.push_back(3'd1);
    irq_in = 8'h02; step(); irq_in = 8'h00;
    step();
    int_ack = 1'b1; step(); int_ack = 1'b0;
    irq_in = 8'h22; step(); irq_in = 8'h00;
    chk("rs_pending", pending, 8'h22);
    chk("rs_in_service", {7'b0, in_service}, 8'h01);
    reset = 1'b0; step(); reset = 1'b1;
    chk("rs_in_service_clr", {7'b0, in_service}, 8'h00);
    chk("rs_pending_clr", pending, 8'h00);
    chk("rs_req", {7'b0, int_req}, 8'h00);
    int_done = 1'b1; step(); int_done = 1'b0;
    step(); step();
    chk("rs_done_ignored_req", {7'b0, int_req}, 8'h00);
    chk("rs_done_ignored_svc", {7'b0, in_service}, 8'h00);

    step();
    chk("queue_drained", 8'(exp_q.size()), 8'h00);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/interrupt_controller.md
# interrupt_controller

Edge-triggered, maskable, fixed-priority interrupt controller between the interrupt sources (periodic timer, button edges) and the single-cycle CPU's interrupt input. It latches rising edges on up to N_IRQ request lines into a pending register, selects the highest-priority unmasked pending line, and presents one request with its vector to the CPU under a req/ack/done handshake. It is not re-entrant: one interrupt is in service at a time.

## Interface
- N_IRQ, 8, number of request lines; line 0 has highest priority
- VEC_W, 3, vector width, equal to ceil(log2(N_IRQ))
- MASK_RESET, 8'hFF, mask register value after reset; 1 = line enabled
- clk  input  1  system clock, all state on rising edge
- reset  input  1  synchronous, active-low reset
- irq_in  input  N_IRQ  level request lines, synchronous to clk; a 0->1 transition is one event
- mask_we  input  1  write strobe for mask register
- mask_in  input  N_IRQ  new mask value, written when mask_we=1
- int_ack  input  1  CPU accepts current request (one-cycle pulse)
- int_done  input  1  CPU finished the service routine (one-cycle pulse)
- int_req  output  1  request to CPU, high only in state REQUEST
- int_vector  output  VEC_W  index of the requested/serviced line
- in_service  output  1  high only in state SERVICE
- pending  output  N_IRQ  current pending register, for status readback
- mask  output  N_IRQ  current mask register

## Operation
- Edge detect: irq_prev registers irq_in every cycle; rise = irq_in & ~irq_prev. During reset irq_prev <= irq_in, so lines already high at reset release produce no event.
- Pending: pending[i] set on any cycle with rise[i]=1, regardless of mask. Cleared only by ack of that line or reset. Repeated edges while pending collapse into one event.
- Mask: mask <= mask_in on mask_we. Masked lines stay pending and become eligible when unmasked.
- Eligible = pending & mask. Selection: lowest set index of eligible.
- FSM states IDLE, REQUEST, SERVICE:
  - IDLE: if eligible != 0, latch int_vector <= selected index, go REQUEST; else stay.
  - REQUEST: int_req=1. On int_ack=1: clear pending[int_vector], go SERVICE. Request is committed: mask writes or new higher-priority edges do not change int_vector or withdraw int_req.
  - SERVICE: in_service=1. On int_done=1 go IDLE. New edges keep accumulating in pending.
- int_ack outside REQUEST and int_done outside SERVICE are ignored.
- Simultaneous rise[int_vector] and int_ack in same cycle: set wins, pending stays 1 (new event not lost).
- Simultaneous mask_we and IDLE selection: selection uses the mask value before the write.
- int_vector holds its value from REQUEST entry until the next IDLE->REQUEST transition.

## Timing
- Reset (reset=0 at a clk edge): state IDLE, pending 0, mask MASK_RESET, int_req 0, int_vector 0, in_service 0. Reset mid-handshake aborts service; pending events are discarded.
- Edge on irq_in first high at edge k: pending visible after edge k; int_req high after edge k+1 (2-cycle latency, IDLE, line unmasked).
- int_ack high at edge m: int_req low and in_service high after edge m.
- int_done high at edge n: in_service low after edge n; if eligible != 0, int_req high again after edge n+1.
- Minimum spacing between serviced interrupts: 1 IDLE cycle.
- All outputs registered except pending/mask readback, which are the registers themselves.

## Test plan
- Reset release with irq_in=8'h01 held high -> pending stays 8'h00, int_req stays 0 for 10 cycles.
- Pulse irq_in[3] one cycle at edge k -> pending=8'h08 after k, int_req=1, int_vector=3 after k+1; ack -> pending=8'h00, in_service=1; done -> in_service=0.
- Edges on lines 5 and 2 same cycle -> first request vector 2, after done second request vector 5, pending ends 8'h00.
- mask=8'hFE, edge on line 0 -> pending=8'h01, int_req stays 0; write mask=8'hFF -> int_req=1, vector 0 two cycles later.
- In REQUEST for line 4, new edge on line 4 same cycle as int_ack -> in_service=1, pending[4] remains 1, second request for vector 4 after done.
- Assert reset during SERVICE with pending=8'h22 -> next cycle in_service=0, pending=8'h00, int_req=0; int_done afterwards ignored.
